// File: rtl/taxi_mac_pause_rx_timer.sv
// Receive pause engine: decodes LFC/PFC control frames into per-class quanta
// counters and counts them down in 512-bit-time quanta for the TX scheduler.
module taxi_mac_pause_rx_timer #(
  parameter int PFC_EN          = 1,
  parameter int MCF_PARAMS_SIZE = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mcf_valid,
  input  logic [15:0]                  mcf_opcode,
  input  logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,
  input  logic [15:0]                  cfg_rx_lfc_opcode,
  input  logic                         cfg_rx_lfc_en,
  input  logic [15:0]                  cfg_rx_pfc_opcode,
  input  logic                         cfg_rx_pfc_en,
  input  logic [15:0]                  cfg_quanta_step,
  input  logic                         cfg_quanta_clk_en,
  output logic                         rx_lfc_req,
  output logic [7:0]                   rx_pfc_req,
  output logic                         stat_rx_lfc_pkt,
  output logic                         stat_rx_pfc_pkt
);

  if (MCF_PARAMS_SIZE < ((PFC_EN != 0) ? 18 : 2)) begin : g_param_check
    $fatal(1, "MCF_PARAMS_SIZE too small for the selected pause modes");
  end

  logic [15:0]      acc, acc_next;
  logic             carry;
  logic [15:0]      lfc_cnt, lfc_cnt_next;
  logic [7:0][15:0] pfc_cnt, pfc_cnt_next;
  logic             lfc_hit, pfc_hit;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    {carry, acc_next} = {1'b0, acc};
    if (cfg_quanta_clk_en) begin
      {carry, acc_next} = {1'b0, acc} + {1'b0, cfg_quanta_step};
    end
  end

  // A frame whose opcode matches the LFC opcode is never treated as PFC.
  assign lfc_hit = mcf_valid && cfg_rx_lfc_en && (mcf_opcode == cfg_rx_lfc_opcode);
  assign pfc_hit = (PFC_EN != 0) && mcf_valid && cfg_rx_pfc_en
                   && (mcf_opcode == cfg_rx_pfc_opcode)
                   && (mcf_opcode != cfg_rx_lfc_opcode);

  // Priority: disable clear, then load, then quanta decrement (saturating).
  always_comb begin
    lfc_cnt_next = lfc_cnt;
    if (!cfg_rx_lfc_en) begin
      lfc_cnt_next = '0;
    end else if (lfc_hit) begin
      lfc_cnt_next = {mcf_params[7:0], mcf_params[15:8]};
    end else if (carry && lfc_cnt != '0) begin
      lfc_cnt_next = lfc_cnt - 16'd1;
    end
  end

  if (PFC_EN != 0) begin : g_pfc
    logic [7:0] pfc_vec;

    always_comb begin
      pfc_vec      = mcf_params[15:8];
      pfc_cnt_next = pfc_cnt;
      for (int n = 0; n < 8; n++) begin
        if (!cfg_rx_pfc_en) begin
          pfc_cnt_next[n] = '0;
        end else if (pfc_hit && pfc_vec[n]) begin
          pfc_cnt_next[n] = {mcf_params[(2+2*n)*8 +: 8], mcf_params[(3+2*n)*8 +: 8]};
        end else if (carry && pfc_cnt[n] != '0) begin
          pfc_cnt_next[n] = pfc_cnt[n] - 16'd1;
        end
      end
    end
  end else begin : g_no_pfc
    always_comb pfc_cnt_next = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc             <= '0;
      lfc_cnt         <= '0;
      pfc_cnt         <= '0;
      rx_lfc_req      <= 1'b0;
      rx_pfc_req      <= '0;
      stat_rx_lfc_pkt <= 1'b0;
      stat_rx_pfc_pkt <= 1'b0;
    end else begin
      acc             <= acc_next;
      lfc_cnt         <= lfc_cnt_next;
      pfc_cnt         <= pfc_cnt_next;
      rx_lfc_req      <= (lfc_cnt_next != '0);
      for (int n = 0; n < 8; n++) begin
        rx_pfc_req[n] <= (pfc_cnt_next[n] != '0);
      end
      stat_rx_lfc_pkt <= lfc_hit;
      stat_rx_pfc_pkt <= pfc_hit;
    end
  end

endmodule

// File: tb/tb_taxi_mac_pause_rx_timer.sv
// Bench for taxi_mac_pause_rx_timer: per-frame output expectations go through
// a scoreboard queue; pause durations are measured in clock cycles.
module tb_taxi_mac_pause_rx_timer;

  logic         clk = 1'b0;
  logic         rst;
  logic         mcf_valid;
  logic [15:0]  mcf_opcode;
  logic [143:0] mcf_params;
  logic [15:0]  cfg_rx_lfc_opcode;
  logic         cfg_rx_lfc_en;
  logic [15:0]  cfg_rx_pfc_opcode;
  logic         cfg_rx_pfc_en;
  logic [15:0]  cfg_quanta_step;
  logic         cfg_quanta_clk_en;
  logic         rx_lfc_req;
  logic [7:0]   rx_pfc_req;
  logic         stat_rx_lfc_pkt;
  logic         stat_rx_pfc_pkt;

  always #5 clk = ~clk;

  taxi_mac_pause_rx_timer #(.PFC_EN(1), .MCF_PARAMS_SIZE(18)) dut (
    .clk               (clk),
    .rst               (rst),
    .mcf_valid         (mcf_valid),
    .mcf_opcode        (mcf_opcode),
    .mcf_params        (mcf_params),
    .cfg_rx_lfc_opcode (cfg_rx_lfc_opcode),
    .cfg_rx_lfc_en     (cfg_rx_lfc_en),
    .cfg_rx_pfc_opcode (cfg_rx_pfc_opcode),
    .cfg_rx_pfc_en     (cfg_rx_pfc_en),
    .cfg_quanta_step   (cfg_quanta_step),
    .cfg_quanta_clk_en (cfg_quanta_clk_en),
    .rx_lfc_req        (rx_lfc_req),
    .rx_pfc_req        (rx_pfc_req),
    .stat_rx_lfc_pkt   (stat_rx_lfc_pkt),
    .stat_rx_pfc_pkt   (stat_rx_pfc_pkt)
  );

  // Expected output vector layout: {lfc_req, pfc_req[7:0], stat_lfc, stat_pfc}
  typedef struct {
    string       tag;
    logic [10:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  function automatic logic [10:0] obs();
    return {rx_lfc_req, rx_pfc_req, stat_rx_lfc_pkt, stat_rx_pfc_pkt};
  endfunction

  task automatic push(input string tag, input logic [10:0] v);
    exp_t x;
    x.tag = tag;
    x.v   = v;
    sb.push_back(x);
  endtask

  // Big-endian 16-bit field i occupies bytes 2i (high) and 2i+1 (low).
  function automatic logic [143:0] put16(input logic [143:0] p, input int i, input logic [15:0] v);
    logic [143:0] r;
    r = p;
    r[i*16 +: 8]   = v[15:8];
    r[i*16+8 +: 8] = v[7:0];
    return r;
  endfunction

  function automatic logic [143:0] lfc_params(input logic [15:0] q);
    return put16('0, 0, q);
  endfunction

  function automatic logic [143:0] pfc_params(input logic [7:0] vec, input logic [7:0][15:0] q);
    logic [143:0] r;
    r = put16('0, 0, {8'h00, vec});
    for (int n = 0; n < 8; n++) r = put16(r, n + 1, q[n]);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the frame's load edge.
  task automatic drive(input logic [15:0] op, input logic [143:0] p);
    mcf_valid  = 1'b1;
    mcf_opcode = op;
    mcf_params = p;
    @(negedge clk);
    mcf_valid  = 1'b0;
    mcf_params = '0;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    mcf_valid         = 1'b0;
    cfg_quanta_clk_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    push("reset", 11'h000);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
  endtask

  task automatic test_lfc_basic();
    int n;
    do_reset();
    cfg_quanta_step   = 16'h8000;
    cfg_quanta_clk_en = 1'b1;
    repeat (9) @(negedge clk);
    push("lfc_load", {1'b1, 8'h00, 1'b1, 1'b0});
    push("lfc_stat_end", {1'b1, 8'h00, 1'b0, 1'b0});
    drive(16'h0001, lfc_params(16'h0010));
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    @(negedge clk);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    n = 1;
    while (rx_lfc_req && n < 200) begin n++; @(negedge clk); end
    total++;
    if (n < 31 || n > 33) begin bad++; $display("FAIL lfc_duration got=%0d cycles want=31..33", n); end
  endtask

  task automatic test_pfc_partial();
    logic [7:0][15:0] q;
    logic [7:0]       snap;
    int               t0, t2;
    do_reset();
    cfg_quanta_step = 16'hFFFF;
    push("pfc_preload", {1'b0, 8'hFF, 1'b0, 1'b1});
    drive(16'h0101, pfc_params(8'hFF, {8{16'h0400}}));
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    q    = {8{16'hFFFF}};
    q[0] = 16'h0003;
    q[2] = 16'h0100;
    push("pfc_partial", {1'b0, 8'hFF, 1'b0, 1'b1});
    drive(16'h0101, pfc_params(8'h05, q));
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    cfg_quanta_clk_en = 1'b1;
    t0 = 0; t2 = 0; snap = '0;
    for (int t = 1; t <= 1030; t++) begin
      @(negedge clk);
      if (!rx_pfc_req[0] && t0 == 0) t0 = t;
      if (!rx_pfc_req[2] && t2 == 0) t2 = t;
      if (t == 1020) snap = rx_pfc_req;
    end
    total++;
    if (t0 - 1 < 2 || t0 - 1 > 4) begin bad++; $display("FAIL pfc0_duration got=%0d want=2..4", t0 - 1); end
    total++;
    if (t2 - 1 < 255 || t2 - 1 > 257) begin bad++; $display("FAIL pfc2_duration got=%0d want=255..257", t2 - 1); end
    total++;
    if (snap !== 8'hFA) begin bad++; $display("FAIL pfc_others_held got=%h want=fa", snap); end
    total++;
    if (rx_pfc_req !== 8'h00) begin bad++; $display("FAIL pfc_others_expired got=%h want=00", rx_pfc_req); end
  endtask

  task automatic test_zero_disable();
    do_reset();
    cfg_quanta_step   = 16'h8000;
    cfg_quanta_clk_en = 1'b1;
    push("lfc_q256", {1'b1, 8'h00, 1'b1, 1'b0});
    drive(16'h0001, lfc_params(16'h0100));
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    repeat (3) @(negedge clk);
    push("lfc_q0", {1'b0, 8'h00, 1'b1, 1'b0});
    drive(16'h0001, lfc_params(16'h0000));
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    push("pfc_q256", {1'b0, 8'hFF, 1'b0, 1'b1});
    drive(16'h0101, pfc_params(8'hFF, {8{16'h0100}}));
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    cfg_rx_pfc_en = 1'b0;
    push("pfc_disable", 11'h000);
    @(negedge clk);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    push("pfc_while_disabled", 11'h000);
    drive(16'h0101, pfc_params(8'hFF, {8{16'h0100}}));
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    cfg_rx_pfc_en = 1'b1;
  endtask

  task automatic test_collision();
    int n;
    do_reset();
    cfg_quanta_step   = 16'h8000;
    cfg_quanta_clk_en = 1'b1;
    @(negedge clk);  // accumulator now 0x8000: the next edge carries
    push("lfc_collide", {1'b1, 8'h00, 1'b1, 1'b0});
    drive(16'h0001, lfc_params(16'h0005));
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    n = 0;
    while (rx_lfc_req && n < 100) begin n++; @(negedge clk); end
    total++;
    if (n != 10) begin bad++; $display("FAIL collide_duration got=%0d cycles want=10", n); end

    do_reset();
    cfg_rx_pfc_opcode = 16'h0001;
    push("same_opcode", {1'b1, 8'h00, 1'b1, 1'b0});
    drive(16'h0001, pfc_params(8'hFF, {8{16'h0010}}));
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    cfg_rx_pfc_opcode = 16'h0101;
  endtask

  task automatic test_reset_mid_pause();
    do_reset();
    push("pre_lfc", {1'b1, 8'h00, 1'b1, 1'b0});
    drive(16'h0001, lfc_params(16'h0100));
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    push("pre_all", {1'b1, 8'hFF, 1'b0, 1'b1});
    drive(16'h0101, pfc_params(8'hFF, {8{16'h0100}}));
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    rst        = 1'b1;
    mcf_valid  = 1'b1;
    mcf_opcode = 16'h0001;
    mcf_params = lfc_params(16'h0200);
    push("rst_mid", 11'h000);
    push("rst_after", 11'h000);
    @(negedge clk);
    rst       = 1'b0;
    mcf_valid = 1'b0;
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    @(negedge clk);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
  endtask

  task automatic test_non_pause();
    do_reset();
    push("np_pre", {1'b1, 8'h00, 1'b1, 1'b0});
    drive(16'h0001, lfc_params(16'h0050));
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    push("np_frame", {1'b1, 8'h00, 1'b0, 1'b0});
    push("np_after", {1'b1, 8'h00, 1'b0, 1'b0});
    drive(16'h0002, lfc_params(16'h0000));
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    @(negedge clk);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push("b2b_lfc", {1'b1, 8'h00, 1'b1, 1'b0});
    push("b2b_pfc", {1'b1, 8'h03, 1'b0, 1'b1});
    push("b2b_idle", {1'b1, 8'h03, 1'b0, 1'b0});
    mcf_valid  = 1'b1;
    mcf_opcode = 16'h0001;
    mcf_params = lfc_params(16'h0020);
    @(negedge clk);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    mcf_opcode = 16'h0101;
    mcf_params = pfc_params(8'h03, {8{16'h0008}});
    @(negedge clk);
    mcf_valid = 1'b0;
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
    @(negedge clk);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, obs(), e.v); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    mcf_valid         = 1'b0;
    mcf_opcode        = '0;
    mcf_params        = '0;
    cfg_rx_lfc_opcode = 16'h0001;
    cfg_rx_lfc_en     = 1'b1;
    cfg_rx_pfc_opcode = 16'h0101;
    cfg_rx_pfc_en     = 1'b1;
    cfg_quanta_step   = 16'h2000;
    cfg_quanta_clk_en = 1'b0;
    @(negedge clk);
    test_reset();
    test_lfc_basic();
    test_pfc_partial();
    test_zero_disable();
    test_collision();
    test_reset_mid_pause();
    test_non_pause();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/taxi_mac_pause_rx_timer.md
# taxi_mac_pause_rx_timer

Receive-side pause engine for the MAC. It sits directly downstream of the MAC control frame receiver and consumes its decoded control-frame interface (`mcf_*`). It decodes 802.3x link-level (LFC) and 802.1Qbb priority (PFC) pause frames, loads per-class pause-quanta counters, and counts them down in 512-bit-time quanta. It presents registered pause-request levels to the transmit scheduler.

## Interface

Parameters:

- `PFC_EN`, default 1: implement the 8 PFC counters. When 0, `rx_pfc_req` is tied to 0.
- `MCF_PARAMS_SIZE`, default 18: byte width of `mcf_params`. Must be ≥18 when `PFC_EN`, ≥2 otherwise; elaboration `$fatal` on violation.

Ports (name, direction, width, meaning):

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `mcf_valid` in 1: single-cycle strobe; a checked control frame is present on the `mcf_*` inputs.
- `mcf_opcode` in 16: control opcode.
- `mcf_params` in `MCF_PARAMS_SIZE*8`: payload after the opcode. Byte k is at `[k*8 +: 8]`, wire order.
- `cfg_rx_lfc_opcode` in 16: LFC opcode, normally 0x0001.
- `cfg_rx_lfc_en` in 1: LFC enable.
- `cfg_rx_pfc_opcode` in 16: PFC opcode, normally 0x0101.
- `cfg_rx_pfc_en` in 1: PFC enable.
- `cfg_quanta_step` in 16: per-cycle quanta increment, fixed-point 0.16. Value = 65536 × bits-per-cycle / 512; for example, 8192 for 64 bits per cycle.
- `cfg_quanta_clk_en` in 1: advance the quanta accumulator this cycle (link up / PHY cycle valid).
- `rx_lfc_req` out 1: link pause active.
- `rx_pfc_req` out 8: per-priority pause active.
- `stat_rx_lfc_pkt` out 1: pulse, LFC frame accepted.
- `stat_rx_pfc_pkt` out 1: pulse, PFC frame accepted.

## Operation

- **Field decode.** All 16-bit fields are big-endian: value = {byte 2i, byte 2i+1}.
  - LFC quanta = bytes 0–1.
  - PFC class-enable vector = bytes 0–1; bit n of the vector enables priority n (bit 0 = LSB of byte 1).
  - PFC quanta[n] = bytes 2+2n and 3+2n.
- **LFC accept.** Condition: `mcf_valid && cfg_rx_lfc_en && mcf_opcode == cfg_rx_lfc_opcode`. Load `lfc_cnt` with the quanta value, replacing the old value (no add). Pulse `stat_rx_lfc_pkt`.
- **PFC accept.** Condition: `mcf_valid && cfg_rx_pfc_en && opcode == cfg_rx_pfc_opcode && PFC_EN`. For each n with enable bit n set, load `pfc_cnt[n]` with quanta[n]. Counters with clear bits are untouched. Pulse `stat_rx_pfc_pkt`, even if the vector is 0.
- **Opcode match order.** LFC is checked first. If both config opcodes are equal, LFC wins and PFC is ignored.
- **Other frames.** Any other `mcf_valid` frame is ignored; no state change.
- **Quanta of 0.** A quanta value of 0 loads 0, which means immediate resume.
- **Quanta accumulator.**
  - When `cfg_quanta_clk_en` is set: `{carry, acc[15:0]} = acc + cfg_quanta_step` (17-bit sum).
  - When `cfg_quanta_clk_en` is clear: `acc` holds and carry = 0.
  - When carry = 1: every nonzero counter decrements by 1. Counters saturate at 0.
- **Load vs. decrement.** If a counter is loaded and a carry occurs in the same cycle, the load wins: the counter takes the new quanta, not quanta−1.
- **Request outputs.** Each `req` bit is a register equal to (next counter value != 0).
- **Enable deassert.** If `cfg_rx_lfc_en` = 0, `lfc_cnt` clears to 0 on the next edge. Likewise, `cfg_rx_pfc_en` = 0 clears all `pfc_cnt`. Clearing has priority over a load.
- **No state machine.** State consists of the accumulator, 9 × 16-bit counters, and the registered outputs.

## Timing

- **Reset values.** `acc` = 0, all counters = 0, `rx_lfc_req` = 0, `rx_pfc_req` = 0, both stat outputs = 0.
  - `rst` mid-pause clears everything on that edge, and any same-cycle `mcf_valid` is dropped.
- **Load latency.** With `mcf_valid` high in cycle N:
  - the counter loads at the end-of-N edge;
  - `req` and the `stat_*` pulse are high in cycle N+1;
  - each stat pulse is exactly 1 cycle.
- **Release latency.** When a carry takes a counter from 1 to 0 at edge E, `req` is low from E onward. An LFC load of 0 at N gives `req` low in N+1.
- **Pause duration.** A frame with quanta Q keeps `req` high for Q carries. With a constant step S, that is ⌈Q·65536/S⌉ cycles, ±1 depending on accumulator phase.
- **Frame rate.** Back-to-back `mcf_valid` strobes are legal, one frame per cycle, with no stall or handshake.

## Test plan

- **LFC basic.** Step = 0x8000, clk_en = 1, LFC frame with quanta 0x0010 in cycle 10 → `rx_lfc_req` rises in cycle 11, falls after 32±1 cycles; `stat_rx_lfc_pkt` high only in cycle 11.
- **PFC partial vector.** Preload all 8 PFC counters to 0x0400. Then send a PFC frame with vector 0x0005, quanta[0] = 0x0003, quanta[2] = 0x0100, others = 0xFFFF → only priorities 0 and 2 reload. Step = 0xFFFF: `rx_pfc_req[0]` drops after ~3 cycles, `[2]` after ~256; the other bits keep their 0x0400 countdown.
- **Zero quanta / disable.** While `rx_lfc_req` = 1, send LFC quanta 0 → req low the next cycle. Separately, deassert `cfg_rx_pfc_en` while paused → all `rx_pfc_req` low the next cycle; a subsequent PFC frame produces no stat pulse.
- **Collision.**
  - Force a carry in the same cycle as an LFC load of 0x0005 → the counter holds 5, not 4; req lasts 5 carries.
  - Equal LFC/PFC config opcodes → only LFC acts.
- **Reset mid-pause.** Assert `rst` for 1 cycle with all nine reqs high and `mcf_valid` present → all reqs and stats 0 afterward; the dropped frame has no effect.
- **Non-pause frame.** Opcode 0x0002 with `mcf_valid` → no counter, req, or stat change.
